hamming_enc_arbiter: RTL and testbench
======================================

# hamming_enc_arbiter

Shares one Hamming(12,8) SEC encoder among NUM_REQ requesters. Arbitration is round-robin, and each requester uses a valid/ready handshake. The result is a single registered codeword stream carrying the winning requester's ID. A one-shot single-bit error injector lets the downstream decoder and scrubber path be exercised in-system. The block sits between the data-producing clients and the protected storage / link write port.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived; do not override).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  8*NUM_REQ  per-requester data byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted on a cycle where req_valid[i] & req_ready[i].
- out_valid  out  1  output register holds a codeword.
- out_ready  in  1  downstream accepts the codeword.
- out_codeword  out  12  encoded word {p3,p2,p1,p0,d7..d0}.
- out_id  out  ID_W  index of the requester whose byte produced out_codeword.
- inj_arm  in  1  pulse; arms a single-bit error for the next accepted request.
- inj_pos  in  4  bit index (0..11) to flip; sampled on the inj_arm cycle.
- inj_pending  out  1  an injection is armed and not yet consumed.

## Operation
- Parity: p0=d0^d1^d3^d4^d6, p1=d0^d2^d3^d5^d6, p2=d1^d2^d3^d7, p3=d4^d5^d6^d7. Codeword bits [11:8]=p3..p0, bits [7:0]=d7..d0.
- Load condition: load = !out_valid | out_ready. Requests are granted only when load=1.
- Grant selection:
  - When load=1, the winner is the first requester with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is one-hot on the winner and all-zero otherwise.
  - At most one grant per cycle.
- Pointer update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. rr_ptr is unchanged when nothing is granted.
- Output register on a grant: out_codeword <= enc(data_i) ^ flip_mask, out_id <= i, out_valid <= 1.
- Output register with no grant: if out_ready & out_valid, then out_valid <= 0. Otherwise it holds.
- Injection:
  - When inj_arm=1, store inj_pos and set inj_pending.
  - On the next grant, flip_mask = 1<<stored_pos, then clear inj_pending.
  - inj_pos >= 12 is still stored and clears pending on use, but flips nothing.
  - If inj_arm=1 on the same cycle as a grant, the grant is not corrupted. The new arm is stored and applies to the following grant.
  - Re-arming while pending overwrites the position.
- Requester rule: req_ready depends combinationally on req_valid, so requesters must not derive req_valid from req_ready. Held data must stay stable while valid.

## Timing
- Reset values: out_valid=0, out_codeword=0, out_id=0, rr_ptr=0, inj_pending=0, stored position=0. req_ready=0 while rst is asserted.
- Latency: a byte accepted in cycle N appears on out_codeword with out_valid=1 in cycle N+1.
- Throughput: one codeword per cycle while out_ready=1 (back-to-back grants).
- Backpressure: while out_valid & !out_ready, req_ready=0 and the output is held stable.
- Fairness: with all requesters continuously valid and out_ready=1, grants cycle 0,1,…,NUM_REQ-1,0,… with no requester starved beyond NUM_REQ-1 cycles of grants.
- Reset mid-operation: the in-flight codeword is discarded, out_valid drops asynchronously, and no partial grant survives.

## Structure
- Shared package hamming_pkg holds: DATA_W=8, CODE_W=12, PAR_W=4, and the parity coverage masks (one 8-bit mask per parity bit: 0x5B, 0x6D, 0x8E, 0xF0).
- Sub-module hamming_12_8_encode: purely combinational, data[7:0] in, codeword[11:0] out. It is instantiated once, after the grant mux.
- Arbiter, pointer, output register and injector live in the top module.

## Test plan
- Single requester 0 sends 0x01, then 0xAA, then 0xFF, with out_ready=1 → out_codeword 0x301, 0x4AA, 0x3FF, each one cycle after acceptance, out_id=0.
- All four requesters valid continuously, out_ready=1 → req_ready one-hot 0001, 0010, 0100, 1000, 0001…, and out_id follows 0,1,2,3,0.
- out_ready held low 3 cycles with a codeword pending → out_codeword and out_id stable, req_ready=0. First cycle out_ready=1 → same-cycle new grant, new word next cycle.
- inj_arm with inj_pos=3, then requester 2 sends 0x00 → out_codeword 0x008, inj_pending 1→0. The next request of 0x00 → 0x000.
- inj_pos=13 armed, data 0xFF → out_codeword 0x3FF, inj_pending cleared.
- rst asserted while out_valid=1 and rr_ptr=2 → out_valid=0 immediately. After release, requesters 1 and 3 valid → requester 1 granted first (rr_ptr=0).

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants for the Hamming(12,8) SEC encoder and its users.
package hamming_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 12;
    localparam int unsigned PAR_W  = 4;

    // Data-bit coverage of each parity bit; element i feeds p[i].
    localparam logic [PAR_W-1:0][DATA_W-1:0] PAR_MASK = {8'hF0, 8'h8E, 8'h6D, 8'h5B};

endpackage

// File: rtl/hamming_12_8_encode.sv
// Combinational Hamming(12,8) encoder: codeword = {p3,p2,p1,p0,d7..d0}.
module hamming_12_8_encode
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] codeword
);

    logic [PAR_W-1:0] par;

    for (genvar i = 0; i < PAR_W; i++) begin : g_par
        assign par[i] = ^(data & PAR_MASK[i]);
    end

    assign codeword = {par, data};

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter sharing one Hamming(12,8) encoder among NUM_REQ clients,
// with a registered codeword output and a one-shot single-bit error injector.
module hamming_enc_arbiter
    import hamming_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CODE_W-1:0]         out_codeword,
    output logic [ID_W-1:0]           out_id,
    input  logic                      inj_arm,
    input  logic [3:0]                inj_pos,
    output logic                      inj_pending
);

    logic [ID_W-1:0]                  rr_ptr;
    logic [ID_W-1:0]                  win;
    logic [ID_W-1:0]                  cand;
    logic                             found;
    logic                             load;
    logic                             grant;
    logic [NUM_REQ-1:0][DATA_W-1:0]   data_arr;
    logic [DATA_W-1:0]                sel_data;
    logic [CODE_W-1:0]                enc_word;
    logic [CODE_W-1:0]                flip_mask;
    logic [3:0]                       inj_pos_q;

    assign data_arr = req_data;
    assign load     = !out_valid || out_ready;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Reset gates the grant so no partial handshake survives it.
    assign grant     = found && load && !rst;
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
    assign sel_data  = data_arr[win];

    // Positions beyond the codeword consume the arm but flip nothing.
    assign flip_mask = (inj_pending && (inj_pos_q < 4'(CODE_W))) ?
                       (CODE_W'(1) << inj_pos_q) : '0;

    hamming_12_8_encode u_enc (
        .data     (sel_data),
        .codeword (enc_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            out_valid    <= 1'b0;
            out_codeword <= '0;
            out_id       <= '0;
            inj_pending  <= 1'b0;
            inj_pos_q    <= '0;
        end else begin
            if (grant) begin
                out_valid    <= 1'b1;
                out_codeword <= enc_word ^ flip_mask;
                out_id       <= win;
                rr_ptr       <= ID_W'((32'(win) + 1) % NUM_REQ);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A same-cycle arm is stored for the following grant.
            if (inj_arm) begin
                inj_pending <= 1'b1;
                inj_pos_q   <= inj_pos;
            end else if (grant) begin
                inj_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Directed bench for hamming_enc_arbiter with a reference model and an expected-output queue.
module tb_hamming_enc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_codeword;
    logic [1:0]  out_id;
    logic        inj_arm;
    logic [3:0]  inj_pos;
    logic        inj_pending;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ptr;
    bit          m_valid;
    bit          m_pend;
    logic [3:0]  m_pos;
    logic [15:0] exp_q[$];

    hamming_enc_arbiter #(.NUM_REQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_id       (out_id),
        .inj_arm      (inj_arm),
        .inj_pos      (inj_pos),
        .inj_pending  (inj_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] enc(input logic [7:0] d);
        logic p0, p1, p2, p3;
        p0 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p1 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p2 = d[1] ^ d[2] ^ d[3] ^ d[7];
        p3 = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {p3, p2, p1, p0, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_pend  = 0;
        m_pos   = '0;
        exp_q.delete();
    endtask

    // One clock with inputs already driven: checks grant, then registered outputs.
    task automatic tick();
        int          win;
        bit          ld;
        logic [11:0] mask;
        logic [7:0]  d;
        #1;
        ld  = !m_valid || out_ready;
        win = -1;
        if (ld) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        chk("req_ready", 32'(req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
        if (m_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (win >= 0) begin
            mask = (m_pend && m_pos < 4'd12) ? (12'd1 << m_pos) : 12'd0;
            d    = req_data[8*win +: 8];
            exp_q.push_back({2'b00, 2'(win), enc(d) ^ mask});
            m_ptr   = (win + 1) % 4;
            m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (inj_arm) begin
            m_pend = 1;
            m_pos  = inj_pos;
        end else if (win >= 0) begin
            m_pend = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid && exp_q.size() > 0) begin
            chk("out_codeword", 32'(out_codeword), 32'(exp_q[0][11:0]));
            chk("out_id", 32'(out_id), 32'(exp_q[0][13:12]));
        end
        chk("inj_pending", 32'(inj_pending), 32'(m_pend));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        out_ready = 1'b1;
        inj_arm   = 1'b0;
        inj_pos   = '0;
        model_reset();

        // Reset state; grants suppressed while rst is high
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_codeword", 32'(out_codeword), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_pending", 32'(inj_pending), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        req_valid = 4'h0;

        // Single requester 0
        req_valid = 4'b0001;
        req_data  = 32'h0000_0001; tick(); chk("cw_01", 32'(out_codeword), 32'h301);
        req_data  = 32'h0000_00AA; tick(); chk("cw_aa", 32'(out_codeword), 32'h4AA);
        req_data  = 32'h0000_00FF; tick(); chk("cw_ff", 32'(out_codeword), 32'h3FF);
        chk("id_0", 32'(out_id), 32'd0);
        req_valid = 4'b0000; tick();

        // All requesters continuously valid: round robin
        req_valid = 4'hF;
        req_data  = 32'hC433_2211;
        for (int n = 0; n < 6; n++) tick();

        // Backpressure for three cycles, then release
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        out_ready = 1'b1;
        tick();
        req_valid = 4'b0000; tick();

        // Inject at bit 3 into requester 2's zero byte
        inj_arm = 1'b1; inj_pos = 4'd3; tick();
        inj_arm = 1'b0;
        req_valid = 4'b0100; req_data = 32'h0000_0000;
        tick(); chk("inj_cw", 32'(out_codeword), 32'h008);
        tick(); chk("inj_clean", 32'(out_codeword), 32'h000);
        req_valid = 4'b0000; tick();

        // Out-of-range position clears pending without flipping
        inj_arm = 1'b1; inj_pos = 4'd13; tick();
        inj_arm = 1'b0;
        req_valid = 4'b0001; req_data = 32'h0000_00FF;
        tick(); chk("inj13_cw", 32'(out_codeword), 32'h3FF);

        // Arm coinciding with a grant applies to the following grant
        req_data = 32'h0000_0000;
        inj_arm = 1'b1; inj_pos = 4'd0; tick(); chk("arm_same_cw", 32'(out_codeword), 32'h000);
        inj_arm = 1'b0; tick(); chk("arm_next_cw", 32'(out_codeword), 32'h001);
        req_valid = 4'b0000; tick();

        // Leave rr_ptr at 2 with a held codeword, then reset asynchronously
        req_valid = 4'b0010; req_data = 32'h0000_5A00; tick();
        req_valid = 4'b0000; out_ready = 1'b0; tick();
        #2;
        rst       = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_id", 32'(out_id), 32'd1);
        req_valid = 4'b0000; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
